sram_bus_bridge: RTL and testbench



---
 rtl/sram_bus_bridge.sv | 173 +++++++++++++++++
 tb/tb_sram_bus_bridge.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_bridge.sv
// sram_bus_bridge: serves NCH fixed-latency SRAM-style CPU channels over one
// variable-latency request/response bus, one transaction at a time, with
// channel 0 at highest priority. The CPU is stalled until every enabled
// channel has completed its access for the current cycle.
// Optional feature: define SRAM_BUS_BRIDGE_PERF_EN to add the stall_cycles_o
// counter port.
module sram_bus_bridge #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NCH    = 2
) (
  input  logic                       clk_i,
  input  logic                       resetn_i,
  input  logic [NCH-1:0]             ch_en_i,
  input  logic [NCH*(DATA_W/8)-1:0]  ch_wen_i,
  input  logic [NCH*ADDR_W-1:0]      ch_addr_i,
  input  logic [NCH*DATA_W-1:0]      ch_wdata_i,
  output logic [NCH*DATA_W-1:0]      ch_rdata_o,
  output logic                       stall_o,
  output logic                       req_o,
  output logic                       wr_o,
  output logic [DATA_W/8-1:0]        wstrb_o,
  output logic [ADDR_W-1:0]          addr_o,
  output logic [DATA_W-1:0]          wdata_o,
  input  logic                       addr_ok_i,
  input  logic                       data_ok_i,
  input  logic [DATA_W-1:0]          rdata_i
`ifdef SRAM_BUS_BRIDGE_PERF_EN
  ,
  output logic [31:0]                stall_cycles_o
`endif
);

  localparam int unsigned STRB = DATA_W / 8;
  localparam int unsigned CurW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e              state_q, state_d;
  logic [NCH-1:0]      done_q, done_d;
  logic [DATA_W-1:0]   rbuf_q [NCH];
  logic [DATA_W-1:0]   rbuf_d [NCH];
  logic [CurW-1:0]     cur_q;
  logic                wr_q;
  logic [STRB-1:0]     wstrb_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic [NCH-1:0]      pending;
  logic [CurW-1:0]     sel_idx;
  logic [STRB-1:0]     sel_wen;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                launch;
  logic                complete;

  assign pending  = ch_en_i & ~done_q;
  assign stall_o  = |pending;
  assign launch   = (state_q == StIdle) && stall_o;
  assign complete = (state_q == StResp) && data_ok_i;

  // Fixed priority: scan from the top so the lowest pending index wins.
  always_comb begin
    sel_idx   = '0;
    sel_wen   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_idx   = CurW'(i);
        sel_wen   = ch_wen_i[i*STRB +: STRB];
        sel_addr  = ch_addr_i[i*ADDR_W +: ADDR_W];
        sel_wdata = ch_wdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; handshakes outside their own state are ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (stall_o)   state_d = StReq;
      StReq:   if (addr_ok_i) state_d = StResp;
      StResp:  if (data_ok_i) state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  // FSM outputs: req is a pure state decode so it drops with reset.
  always_comb begin
    req_o = (state_q == StReq);
  end

  // Request fields are captured at the decision and held through REQ/RESP.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      cur_q   <= '0;
      wr_q    <= 1'b0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (launch) begin
      cur_q   <= sel_idx;
      wr_q    <= |sel_wen;
      wstrb_q <= sel_wen;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
    end
  end

  // Completion marks the channel done; a stall-free cycle releases the CPU
  // and clears every done flag at that edge.
  always_comb begin
    done_d = done_q;
    rbuf_d = rbuf_q;
    if (complete) begin
      done_d[cur_q] = 1'b1;
      if (!wr_q) begin
        rbuf_d[cur_q] = rdata_i;
      end
    end
    if (!stall_o) begin
      done_d = '0;
    end
  end

  // Per-channel done flags and read buffers.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      done_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        rbuf_q[i] <= '0;
      end
    end else begin
      done_q <= done_d;
      rbuf_q <= rbuf_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_rdata
    assign ch_rdata_o[g*DATA_W +: DATA_W] = rbuf_q[g];
  end

  assign wr_o    = wr_q;
  assign wstrb_o = wstrb_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;

`ifdef SRAM_BUS_BRIDGE_PERF_EN
  logic [31:0] stall_cycles_q;

  // Free-running stall counter; wraps naturally, cleared only by reset.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      stall_cycles_q <= '0;
    end else if (stall_o) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
`endif

endmodule

// File: tb/tb_sram_bus_bridge.sv
// Self-checking bench for sram_bus_bridge: a transaction-level model predicts
// the request sequence, stall duration and read buffers of each CPU cycle.
module tb_sram_bus_bridge;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int NCH    = 2;
  localparam int STRB   = DATA_W / 8;

  logic                    clk = 1'b0;
  logic                    resetn;
  logic [NCH-1:0]          ch_en;
  logic [NCH*STRB-1:0]     ch_wen;
  logic [NCH*ADDR_W-1:0]   ch_addr;
  logic [NCH*DATA_W-1:0]   ch_wdata;
  logic [NCH*DATA_W-1:0]   ch_rdata;
  logic                    stall, req, wr;
  logic [STRB-1:0]         wstrb;
  logic [ADDR_W-1:0]       addr;
  logic [DATA_W-1:0]       wdata;
  logic                    addr_ok, data_ok;
  logic [DATA_W-1:0]       rdata;
`ifdef SRAM_BUS_BRIDGE_PERF_EN
  logic [31:0]             stall_cycles;
`endif

  always #5 clk = ~clk;

  sram_bus_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NCH(NCH)) dut (
    .clk_i          (clk),
    .resetn_i       (resetn),
    .ch_en_i        (ch_en),
    .ch_wen_i       (ch_wen),
    .ch_addr_i      (ch_addr),
    .ch_wdata_i     (ch_wdata),
    .ch_rdata_o     (ch_rdata),
    .stall_o        (stall),
    .req_o          (req),
    .wr_o           (wr),
    .wstrb_o        (wstrb),
    .addr_o         (addr),
    .wdata_o        (wdata),
    .addr_ok_i      (addr_ok),
    .data_ok_i      (data_ok),
    .rdata_i        (rdata)
`ifdef SRAM_BUS_BRIDGE_PERF_EN
    ,
    .stall_cycles_o (stall_cycles)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          ch;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wr;
    int          a;      // cycles addr_ok is withheld in REQ
    int          d;      // cycles data_ok is withheld in RESP
    logic [31:0] rdata;
  } txn_t;

  txn_t        q[$];
  logic [31:0] m_rbuf [NCH];
  int          fix_a = -1;
  int          fix_d = -1;
  logic        fix_rd_en = 1'b0;
  logic [31:0] fix_rd = '0;

  // One CPU cycle: drive the channels, act as the slave, check everything
  // against the transaction list until the bridge releases the CPU.
  task automatic run_op(input logic [NCH-1:0] en, input logic [NCH*STRB-1:0] wen,
                        input logic [NCH*ADDR_W-1:0] ad, input logic [NCH*DATA_W-1:0] wd);
    int   exp_stalls = 0;
    int   exp_reqs   = 0;
    int   stalls     = 0;
    int   reqs       = 0;
    int   guard      = 0;
    int   wcnt       = 0;
    int   dcnt       = 0;
    bit   in_data    = 0;
    txn_t t;
    q.delete();
    for (int i = 0; i < NCH; i++) begin
      if (en[i]) begin
        t.ch    = i;
        t.addr  = ad[i*ADDR_W +: ADDR_W];
        t.wdata = wd[i*DATA_W +: DATA_W];
        t.wstrb = wen[i*STRB +: STRB];
        t.wr    = |t.wstrb;
        t.a     = (fix_a >= 0) ? fix_a : int'($urandom_range(4, 0));
        t.d     = (fix_d >= 0) ? fix_d : int'($urandom_range(4, 0));
        t.rdata = fix_rd_en ? fix_rd : $urandom;
        exp_stalls += 3 + t.a + t.d;
        exp_reqs   += 1 + t.a;
        q.push_back(t);
      end
    end
    ch_en = en; ch_wen = wen; ch_addr = ad; ch_wdata = wd;
    #1;
    while (stall) begin
      stalls++;
      addr_ok = 1'b0; data_ok = 1'b0; rdata = $urandom;
      if (!in_data) begin
        if (req) begin
          reqs++;
          if (q.size() == 0) begin
            check_eq("extra_req", 64'(req), 64'(0));
          end else begin
            check_eq("req_addr",  64'(addr),  64'(q[0].addr));
            check_eq("req_wr",    64'(wr),    64'(q[0].wr));
            check_eq("req_wstrb", 64'(wstrb), 64'(q[0].wstrb));
            check_eq("req_wdata", 64'(wdata), 64'(q[0].wdata));
            if (wcnt == q[0].a) begin
              addr_ok = 1'b1; in_data = 1; dcnt = 0;
            end else begin
              data_ok = 1'($urandom_range(1, 0));  // must be ignored in REQ
            end
            wcnt++;
          end
        end else begin
          addr_ok = 1'($urandom_range(1, 0));    // must be ignored in IDLE
        end
      end else begin
        check_eq("req_low_resp", 64'(req), 64'(0));
        addr_ok = 1'($urandom_range(1, 0));      // must be ignored in RESP
        if (dcnt == q[0].d) begin
          data_ok = 1'b1;
          rdata   = q[0].rdata;
          if (!q[0].wr) m_rbuf[q[0].ch] = q[0].rdata;
          void'(q.pop_front());
          in_data = 0; wcnt = 0;
        end
        dcnt++;
      end
      @(posedge clk); @(negedge clk);
      guard++;
      if (guard > 200) begin
        check_eq("timeout", 64'(stall), 64'(0));
        break;
      end
    end
    addr_ok = 1'b0; data_ok = 1'b0;
    check_eq("stall_cycles", 64'(stalls), 64'(exp_stalls));
    check_eq("req_cycles",   64'(reqs),   64'(exp_reqs));
    check_eq("txn_left",     64'(q.size()), 64'(0));
    check_eq("req_release",  64'(req),    64'(0));
    for (int i = 0; i < NCH; i++) begin
      check_eq($sformatf("ch_rdata%0d", i), 64'(ch_rdata[i*DATA_W +: DATA_W]), 64'(m_rbuf[i]));
    end
    q.delete();
    @(posedge clk); @(negedge clk);  // release edge with inputs still held
  endtask

  task automatic dual_zero_wait();
    fix_a = 0; fix_d = 0;
    run_op(2'b11, {4'b0000, 4'b0011}, {32'h0000_2000, 32'h0000_1000},
           {32'h0BAD_F00D, 32'h1234_5678});
    fix_a = -1; fix_d = -1;
  endtask

  initial begin
    logic [NCH*STRB-1:0]   wen_r;
    logic [NCH*ADDR_W-1:0] ad_r;
    logic [NCH*DATA_W-1:0] wd_r;
    for (int i = 0; i < NCH; i++) m_rbuf[i] = '0;
    resetn = 1'b0; ch_en = '0; ch_wen = '0; ch_addr = '0; ch_wdata = '0;
    addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
    #1;
    check_eq("rst_req",    64'(req),      64'(0));
    check_eq("rst_wr",     64'(wr),       64'(0));
    check_eq("rst_wstrb",  64'(wstrb),    64'(0));
    check_eq("rst_addr",   64'(addr),     64'(0));
    check_eq("rst_wdata",  64'(wdata),    64'(0));
    check_eq("rst_rdata",  64'(ch_rdata), 64'(0));
    check_eq("rst_stall0", 64'(stall),    64'(0));
    ch_en = 2'b01; #1;
    check_eq("rst_stall1", 64'(stall),    64'(1));
    ch_en = '0;
    @(posedge clk); @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); @(negedge clk);

`ifdef SRAM_BUS_BRIDGE_PERF_EN
    dual_zero_wait();
    dual_zero_wait();
    check_eq("perf_count", 64'(stall_cycles), 64'(12));
    force dut.stall_cycles_q = 32'hFFFF_FFFF;
    #1 release dut.stall_cycles_q;
    ch_en = 2'b01; ch_wen = '0;
    @(posedge clk); #1;
    check_eq("perf_wrap", 64'(stall_cycles), 64'(0));
    @(negedge clk);
    addr_ok = 1'b1;
    @(posedge clk); @(negedge clk);
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h0;
    m_rbuf[0] = 32'h0;
    @(posedge clk); @(negedge clk);
    data_ok = 1'b0;
    @(posedge clk); @(negedge clk);
    ch_en = '0;
`endif

    // Single read with the boot address.
    fix_a = 0; fix_d = 0; fix_rd_en = 1'b1; fix_rd = 32'hDEAD_BEEF;
    run_op(2'b01, '0, {32'h0, 32'h1FC0_0000}, '0);
    fix_rd_en = 1'b0;
    check_eq("boot_rdata", 64'(ch_rdata[DATA_W-1:0]), 64'(32'hDEAD_BEEF));

    // Dual channel: ch0 write then ch1 read, 6 stall cycles.
    dual_zero_wait();

    // Backpressure: REQ held 6 cycles, RESP 5 cycles.
    fix_a = 5; fix_d = 4;
    run_op(2'b01, '0, {32'h0, 32'h0000_4000}, '0);
    fix_a = -1; fix_d = -1;

    // Idle CPU cycle: no stall, no request.
    run_op(2'b00, '0, '0, '0);

    // Reset while in RESP abandons the access.
    ch_en = 2'b01; ch_wen = '0; ch_addr = {32'h0, 32'h0000_8000};
    @(posedge clk); @(negedge clk);
    check_eq("rst_pre_req", 64'(req), 64'(1));
    addr_ok = 1'b1;
    @(posedge clk); @(negedge clk);
    addr_ok = 1'b0;
    resetn = 1'b0; #1;
    check_eq("rstm_req",   64'(req),      64'(0));
    check_eq("rstm_stall", 64'(stall),    64'(1));
    check_eq("rstm_rdata", 64'(ch_rdata), 64'(0));
    check_eq("rstm_addr",  64'(addr),     64'(0));
    for (int i = 0; i < NCH; i++) m_rbuf[i] = '0;
    @(posedge clk); @(negedge clk);
    resetn = 1'b1;
    fix_a = 0; fix_d = 0;
    run_op(2'b01, '0, {32'h0, 32'h0000_8000}, '0);
    fix_a = -1; fix_d = -1;

    // Randomized CPU cycles with random delays and spurious handshakes.
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NCH; i++) begin
        wen_r[i*STRB +: STRB] = ($urandom_range(1, 0) == 1) ? 4'($urandom_range(15, 1)) : 4'h0;
      end
      ad_r = {$urandom, $urandom};
      wd_r = {$urandom, $urandom};
      run_op(2'($urandom_range(3, 0)), wen_r, ad_r, wd_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
